// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback arbiter and its load-result buffer.
package wb_pkg;
  localparam logic [4:0] REG_X0     = 5'd0;
  localparam int         REG_ADDR_W = 5;
  localparam int         DATA_W     = 32;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_ALU,
    SRC_LOAD
  } wb_src_e;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [DATA_W-1:0]     data;
  } wb_entry_t;
endpackage

// File: rtl/wb_load_fifo.sv
// Load-result buffer: power-of-two circular FIFO with occupancy count and a
// combinational head view.
module wb_load_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  wb_entry_t                push_entry,
  output logic [$clog2(DEPTH):0]   count,
  output wb_entry_t                head
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  wb_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_entry;
  end

  assign head = mem[rd_ptr];
endmodule

// File: rtl/writeback_arbiter.sv
// Single-port register-file writeback arbiter: ALU first, then buffered loads,
// then a same-cycle load bypass. Optional scoreboard under WB_SCOREBOARD_EN.
module writeback_arbiter
  import wb_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [4:0]  ld_rd,
  input  logic [31:0] ld_data,
  output logic        stall_req,
  input  logic        ld_issue,
  input  logic [4:0]  ld_issue_rd,
  output logic [31:0] pending,
  output logic        regWrite,
  output logic [4:0]  regAddrWrite,
  output logic [31:0] regWriteData
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [CNT_W-1:0]      count;
  wb_entry_t             head;
  wb_entry_t             ld_entry;
  wb_src_e               sel;
  logic [REG_ADDR_W-1:0] sel_rd;
  logic [DATA_W-1:0]     sel_data;
  logic                  ld_acc;
  logic                  ld_keep;
  logic                  pop;
  logic                  push;
  logic                  bypass;
  logic                  wr_en;
  logic                  ld_wb;

  assign ld_ready  = !rst && (count < CNT_W'(FIFO_DEPTH));
  assign stall_req = (count == CNT_W'(FIFO_DEPTH));
  assign ld_acc    = ld_valid && ld_ready;
  // Loads to x0 finish their handshake but never occupy the buffer.
  assign ld_keep   = ld_acc && (ld_rd != REG_X0);
  assign ld_entry  = '{rd: ld_rd, data: ld_data};

  always_comb begin
    sel      = SRC_NONE;
    sel_rd   = REG_X0;
    sel_data = '0;
    pop      = 1'b0;
    bypass   = 1'b0;
    if (alu_valid) begin
      sel      = SRC_ALU;
      sel_rd   = alu_rd;
      sel_data = alu_data;
    end else if (count != '0) begin
      sel      = SRC_LOAD;
      sel_rd   = head.rd;
      sel_data = head.data;
      pop      = 1'b1;
    end else if (ld_keep) begin
      sel      = SRC_LOAD;
      sel_rd   = ld_rd;
      sel_data = ld_data;
      bypass   = 1'b1;
    end
  end

  assign push  = ld_keep && !bypass;
  assign wr_en = (sel != SRC_NONE) && (sel_rd != REG_X0);

  wb_load_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .pop        (pop),
    .push_entry (ld_entry),
    .count      (count),
    .head       (head)
  );

  // Address and data only move on a real write so idle cycles hold them.
  always_ff @(posedge clk) begin
    if (rst) begin
      regWrite     <= 1'b0;
      regAddrWrite <= '0;
      regWriteData <= '0;
      ld_wb        <= 1'b0;
    end else begin
      regWrite <= wr_en;
      ld_wb    <= wr_en && (sel == SRC_LOAD);
      if (wr_en) begin
        regAddrWrite <= sel_rd;
        regWriteData <= sel_data;
      end
    end
  end

`ifdef WB_SCOREBOARD_EN
  logic [31:0] pending_next;

  // Set is applied after clear so a same-cycle re-issue keeps the bit high.
  always_comb begin
    pending_next = pending;
    if (regWrite && ld_wb) pending_next[regAddrWrite] = 1'b0;
    if (ld_issue && (ld_issue_rd != REG_X0)) pending_next[ld_issue_rd] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) pending <= '0;
    else     pending <= pending_next;
  end
`else
  logic unused_sb;
  assign unused_sb = ^{ld_issue, ld_issue_rd, ld_wb};
  assign pending   = '0;
`endif
endmodule

// File: tb/tb_writeback_arbiter.sv
// Randomized bench for writeback_arbiter against a queue-based reference model.
module tb_writeback_arbiter;
  localparam int DEPTH = 2;
`ifdef WB_SCOREBOARD_EN
  localparam bit SB = 1'b1;
`else
  localparam bit SB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        ld_valid;
  logic        ld_ready;
  logic [4:0]  ld_rd;
  logic [31:0] ld_data;
  logic        stall_req;
  logic        ld_issue;
  logic [4:0]  ld_issue_rd;
  logic [31:0] pending;
  logic        regWrite;
  logic [4:0]  regAddrWrite;
  logic [31:0] regWriteData;

  writeback_arbiter #(.FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
    .stall_req(stall_req), .ld_issue(ld_issue), .ld_issue_rd(ld_issue_rd),
    .pending(pending), .regWrite(regWrite), .regAddrWrite(regAddrWrite),
    .regWriteData(regWriteData)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: load buffer as a queue, register-file port as plain state.
  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ld_t;

  ld_t         q[$];
  logic        m_we   = 1'b0;
  logic [4:0]  m_addr = '0;
  logic [31:0] m_data = '0;
  logic        m_ldwb = 1'b0;
  logic [31:0] m_pend = '0;

  task automatic cycle(input logic r, input logic av, input logic [4:0] ard,
                       input logic [31:0] ad, input logic lv, input logic [4:0] lrd,
                       input logic [31:0] ldd, input logic iss, input logic [4:0] ird);
    logic        acc;
    logic        byp;
    logic        n_we;
    logic [4:0]  n_addr;
    logic [31:0] n_data;
    logic        n_ldwb;
    logic [31:0] n_pend;
    ld_t         e;
    rst = r; alu_valid = av; alu_rd = ard; alu_data = ad;
    ld_valid = lv; ld_rd = lrd; ld_data = ldd; ld_issue = iss; ld_issue_rd = ird;
    #1;
    chk("ld_ready", 32'(ld_ready), 32'(!r && q.size() < DEPTH));
    chk("stall_req", 32'(stall_req), 32'(q.size() == DEPTH));
    acc = lv && !r && (q.size() < DEPTH);
    byp = 1'b0;
    n_we = 1'b0; n_addr = m_addr; n_data = m_data; n_ldwb = 1'b0;
    if (r) begin
      q.delete();
      n_addr = '0; n_data = '0; n_pend = '0;
    end else begin
      if (av) begin
        if (ard != 5'd0) begin n_we = 1'b1; n_addr = ard; n_data = ad; end
      end else if (q.size() > 0) begin
        e = q.pop_front();
        n_we = 1'b1; n_addr = e.rd; n_data = e.data; n_ldwb = 1'b1;
      end else if (acc && lrd != 5'd0) begin
        n_we = 1'b1; n_addr = lrd; n_data = ldd; n_ldwb = 1'b1; byp = 1'b1;
      end
      if (acc && lrd != 5'd0 && !byp) q.push_back('{rd: lrd, data: ldd});
      n_pend = m_pend;
      if (SB) begin
        if (m_we && m_ldwb) n_pend[m_addr] = 1'b0;
        if (iss && ird != 5'd0) n_pend[ird] = 1'b1;
      end
    end
    @(posedge clk);
    m_we = n_we; m_addr = n_addr; m_data = n_data; m_ldwb = n_ldwb; m_pend = n_pend;
    #1;
    chk("regWrite", 32'(regWrite), 32'(m_we));
    chk("regAddrWrite", 32'(regAddrWrite), 32'(m_addr));
    chk("regWriteData", regWriteData, m_data);
    chk("pending", pending, m_pend);
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
  endtask

  initial begin
    // Reset state
    cycle(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    cycle(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    chk("rst_regWrite", 32'(regWrite), 32'd0);
    chk("rst_pending", pending, 32'd0);

    // Single ALU write appears one cycle later and only once
    cycle(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    chk("alu_we", 32'(regWrite), 32'd1);
    chk("alu_addr", 32'(regAddrWrite), 32'd5);
    chk("alu_data", regWriteData, 32'hDEADBEEF);
    idle();
    chk("alu_once", 32'(regWrite), 32'd0);
    chk("hold_data", regWriteData, 32'hDEADBEEF);

    // Same-cycle ALU and load: ALU first, load next
    cycle(1'b0, 1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22, 1'b0, 5'd0);
    chk("both_first", 32'(regAddrWrite), 32'd3);
    idle();
    chk("both_second_addr", 32'(regAddrWrite), 32'd4);
    chk("both_second_data", regWriteData, 32'h22);

    // Fill the buffer behind a stream of ALU writes, then drain in order
    cycle(1'b0, 1'b1, 5'd1, 32'hA1, 1'b1, 5'd10, 32'h100, 1'b0, 5'd0);
    cycle(1'b0, 1'b1, 5'd2, 32'hA2, 1'b1, 5'd11, 32'h101, 1'b0, 5'd0);
    cycle(1'b0, 1'b1, 5'd3, 32'hA3, 1'b1, 5'd12, 32'h102, 1'b0, 5'd0);
    chk("full_stall", 32'(stall_req), 32'd1);
    chk("full_ready", 32'(ld_ready), 32'd0);
    cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 32'h102, 1'b0, 5'd0);
    chk("drain0", 32'(regAddrWrite), 32'd10);
    cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 32'h102, 1'b0, 5'd0);
    chk("drain1", 32'(regAddrWrite), 32'd11);
    idle();
    chk("drain2", 32'(regAddrWrite), 32'd12);
    chk("drain2_data", regWriteData, 32'h102);
    chk("ready_back", 32'(ld_ready), 32'd1);

    // rd 0 on both paths: no writes, nothing buffered
    cycle(1'b0, 1'b1, 5'd0, 32'h55, 1'b1, 5'd0, 32'h66, 1'b0, 5'd0);
    chk("x0_no_write", 32'(regWrite), 32'd0);
    idle();
    chk("x0_no_load", 32'(regWrite), 32'd0);

    // Scoreboard set, clear, and set-wins-over-clear
    cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7);
    chk("pend_set", 32'(pending[7]), 32'(SB));
    cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h77, 1'b0, 5'd0);
    idle();
    chk("pend_clr", 32'(pending[7]), 32'd0);
    cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7);
    cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h78, 1'b0, 5'd0);
    cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7);
    chk("pend_set_wins", 32'(pending[7]), 32'(SB));

    // Reset with two buffered loads discards them
    cycle(1'b0, 1'b1, 5'd1, 32'hB1, 1'b1, 5'd20, 32'h200, 1'b1, 5'd9);
    cycle(1'b0, 1'b1, 5'd2, 32'hB2, 1'b1, 5'd21, 32'h201, 1'b0, 5'd0);
    chk("pre_rst_stall", 32'(stall_req), 32'd1);
    cycle(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    chk("rst_mid_we", 32'(regWrite), 32'd0);
    chk("rst_mid_pend", pending, 32'd0);
    for (int i = 0; i < 4; i++) idle();
    chk("rst_mid_ready", 32'(ld_ready), 32'd1);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 99) == 0,
            $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom,
            $urandom_range(0, 2) != 0, 5'($urandom_range(0, 7)), $urandom,
            $urandom_range(0, 3) == 0, 5'($urandom_range(0, 7)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
